// File: rtl/rv_fetch_queue.sv
// Instruction-fetch front end: sequential fetch requests with credit-based flow control,
// an in-order response FIFO tagged with PCs, and redirect flushing of buffered/in-flight fetches.
module rv_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,

    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [XLEN-1:0]        imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [31:0]            imem_rsp_data,

    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,

    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst_data,
    output logic [XLEN-1:0]        inst_pc,
    output logic [XLEN-1:0]        inst_pc_plus4,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned CW1 = CW + 1;

    localparam logic [CW-1:0]   DepthC = CW'(DEPTH);
    localparam logic [CW1-1:0]  DepthW = CW1'(DEPTH);
    localparam logic [XLEN-1:0] Four   = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [31:0]     mem_data_q [DEPTH];
    logic [XLEN-1:0] mem_pc_q   [DEPTH];

    logic [CW-1:0]   live;
    logic [CW1-1:0]  committed;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_fire;
    logic            push;
    logic            pop;
    logic            has_head;
    logic [XLEN-1:0] redirect_tgt;
    logic [XLEN-1:0] head_pc;
    logic            unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Entries already buffered plus live (non-dropped) fetches must fit in the FIFO,
    // so every accepted response always has a free slot.
    assign live      = inflight_q - drop_q;
    assign committed = {1'b0, count_q} + {1'b0, live};
    assign credit_ok = (committed < DepthW) && (inflight_q < DepthC);

    // rst_n gating keeps the request channel quiet while reset is held.
    assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && (inflight_q != '0);
    assign push     = rsp_fire && (drop_q == '0) && !redirect_valid;

    assign has_head   = (count_q != '0);
    assign inst_valid = has_head && !redirect_valid;
    assign pop        = inst_valid && inst_ready;

    assign head_pc       = mem_pc_q[rd_ptr_q];
    assign inst_data     = has_head ? mem_data_q[rd_ptr_q] : '0;
    assign inst_pc       = has_head ? head_pc : '0;
    assign inst_pc_plus4 = has_head ? head_pc + Four : '0;
    assign fifo_count    = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
        count_d    = count_q + CW'(push) - CW'(pop);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + Four;
        end
        if (rsp_fire && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (push) begin
            rsp_pc_d = rsp_pc_q + Four;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Everything still outstanding belongs to the old path; a response landing in
        // the redirect cycle is already consumed here, hence the subtraction.
        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            drop_d     = inflight_q - CW'(rsp_fire);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: the head is only exposed while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= imem_rsp_data;
            mem_pc_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == DepthC)));
    a_drop_le_inflight: assert property (@(posedge clk) disable iff (!rst_n)
        drop_q <= inflight_q);

endmodule
